// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - PC sequencer control inputs and fetch/status outputs
interface pc_sequencer_if;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        exc;
  logic        halt;
  logic        resume;
  logic        imem_ready;
  logic [15:0] pc_out;
  logic        fetch_valid;
  logic        flush;
  logic [15:0] epc;
  logic [1:0]  state;

  modport slave (
    input  stall, br_taken, br_target, jmp, jmp_target, exc, halt, resume, imem_ready,
    output pc_out, fetch_valid, flush, epc, state
  );

  modport master (
    output stall, br_taken, br_target, jmp, jmp_target, exc, halt, resume, imem_ready,
    input  pc_out, fetch_valid, flush, epc, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with redirect, memory-wait and halt handling
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] EXC_VEC  = 16'h0100,
  parameter logic [15:0] INC      = 16'd2
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    WAIT_MEM = 2'b10,
    HALT     = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] epc_q, epc_d;
  logic        flush_q, flush_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_target_q, pend_target_d;

  logic        redir;
  logic [15:0] redir_target;

  // Winning redirect this cycle: exception beats branch beats jump.
  always_comb begin
    redir        = bus.exc | bus.br_taken | bus.jmp;
    redir_target = bus.jmp_target;
    if (bus.exc) begin
      redir_target = EXC_VEC;
    end else if (bus.br_taken) begin
      redir_target = bus.br_target;
    end
  end

  // Next-state and datapath decisions; flush defaults low so it only pulses.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    flush_d       = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (redir) begin
          pc_d    = redir_target;
          flush_d = 1'b1;
          if (bus.exc) begin
            epc_d = pc_q;
          end
        end else if (bus.halt) begin
          state_d = HALT;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (!bus.imem_ready) begin
          state_d = WAIT_MEM;
        end else begin
          pc_d = pc_q + INC;
        end
      end

      WAIT_MEM: begin
        // The outstanding fetch at pc_q must complete, so redirects are parked.
        if (redir) begin
          flush_d       = 1'b1;
          pend_valid_d  = 1'b1;
          pend_target_d = redir_target;
          if (bus.exc) begin
            epc_d = pc_q;
          end
        end
        if (bus.imem_ready) begin
          state_d      = RUN;
          pend_valid_d = 1'b0;
          if (redir) begin
            pc_d = redir_target;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d = pc_q + INC;
          end
        end
      end

      HALT: begin
        if (bus.resume) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      epc_q         <= 16'h0000;
      flush_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      flush_q       <= flush_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.epc         = epc_q;
  assign bus.flush       = flush_q;
  assign bus.state       = state_q;
  assign bus.fetch_valid = (state_q == RUN) || (state_q == WAIT_MEM);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] EXC_VEC  = 16'h0100;
  localparam logic [15:0] INC      = 16'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .INC(INC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] epc;
    logic        flush;
    logic [1:0]  st;
    logic        fv;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural view in terms of the documented rules.
  logic [15:0] m_pc, m_epc, m_pend_t;
  logic        m_flush, m_pend_v;
  logic [1:0]  m_mode;   // 0 boot, 1 run, 2 waiting on memory, 3 halted

  function automatic void model_reset();
    m_pc     = RESET_PC;
    m_epc    = 16'h0000;
    m_flush  = 1'b0;
    m_pend_v = 1'b0;
    m_pend_t = 16'h0000;
    m_mode   = 2'd0;
  endfunction

  function automatic void model_step();
    logic        any_redir;
    logic [15:0] tgt;
    logic        nf;
    any_redir = bus.exc || bus.br_taken || bus.jmp;
    tgt = bus.exc ? EXC_VEC : (bus.br_taken ? bus.br_target : bus.jmp_target);
    nf  = 1'b0;
    if (m_mode == 2'd0) begin
      m_mode = 2'd1;
    end else if (m_mode == 2'd1) begin
      if (any_redir) begin
        if (bus.exc) m_epc = m_pc;
        m_pc = tgt;
        nf   = 1'b1;
      end else if (bus.halt) begin
        m_mode = 2'd3;
      end else if (!bus.stall && !bus.imem_ready) begin
        m_mode = 2'd2;
      end else if (!bus.stall) begin
        m_pc = m_pc + INC;
      end
    end else if (m_mode == 2'd2) begin
      if (any_redir) begin
        if (bus.exc) m_epc = m_pc;
        m_pend_v = 1'b1;
        m_pend_t = tgt;
        nf       = 1'b1;
      end
      if (bus.imem_ready) begin
        m_pc     = m_pend_v ? m_pend_t : m_pc + INC;
        m_pend_v = 1'b0;
        m_mode   = 2'd1;
      end
    end else begin
      if (bus.resume) m_mode = 2'd1;
    end
    m_flush = nf;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.flush = m_flush;
    e.st    = m_mode;
    e.fv    = (m_mode == 2'd1) || (m_mode == 2'd2);
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: after every sampling point, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out",      bus.pc_out,             e.pc);
        chk("epc",         bus.epc,                e.epc);
        chk("flush",       {15'd0, bus.flush},     {15'd0, e.flush});
        chk("state",       {14'd0, bus.state},     {14'd0, e.st});
        chk("fetch_valid", {15'd0, bus.fetch_valid}, {15'd0, e.fv});
      end
    end
  end

  task automatic drive(input logic r, input logic st, input logic ir,
                       input logic e, input logic b, input logic [15:0] bt,
                       input logic j, input logic [15:0] jt,
                       input logic h, input logic rs);
    @(negedge clk);
    rst            = r;
    bus.stall      = st;
    bus.imem_ready = ir;
    bus.exc        = e;
    bus.br_taken   = b;
    bus.br_target  = bt;
    bus.jmp        = j;
    bus.jmp_target = jt;
    bus.halt       = h;
    bus.resume     = rs;
    if (!r) model_reset();
    else    model_step();
    push_exp();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 0);
  endtask

  task automatic jump_to(input logic [15:0] t);
    drive(1, 0, 1, 0, 0, 16'h0, 1, t, 0, 0);
  endtask

  initial begin
    bus.stall = 0; bus.imem_ready = 1; bus.exc = 0; bus.br_taken = 0;
    bus.br_target = 0; bus.jmp = 0; bus.jmp_target = 0; bus.halt = 0; bus.resume = 0;
    model_reset();

    // Reset held, then release and free-run from RESET_PC
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    run(9);                                        // BOOT, then 0000..0010

    // Exception and branch together at 0010: exception wins
    drive(1, 0, 1, 1, 1, 16'h0040, 0, 16'h0, 0, 0);
    run(2);

    // Memory wait with a parked jump
    jump_to(16'h0020);
    drive(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(1, 0, 0, 0, 0, 16'h0, 1, 16'h0080, 0, 0);
    drive(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(1, 1, 1, 0, 0, 16'h0, 0, 16'h0, 1, 0);   // stall/halt ignored while waiting
    run(1);

    // Wrap-around of the sequential increment
    jump_to(16'hFFFC);
    run(3);

    // Halt ignores redirects, resume keeps the PC
    jump_to(16'h0030);
    drive(1, 0, 1, 0, 0, 16'h0, 0, 16'h0, 1, 0);
    drive(1, 0, 1, 1, 1, 16'h0055, 1, 16'h0066, 0, 0);
    drive(1, 1, 1, 0, 0, 16'h0, 0, 16'h0, 1, 0);
    drive(1, 0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 1);
    run(1);

    // Exception in memory wait completing the same cycle
    drive(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(1, 0, 1, 1, 0, 16'h0, 1, 16'h1234, 0, 0);
    run(1);

    // Mid-cycle reset while a redirect is parked
    jump_to(16'h0040);
    drive(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(1, 0, 0, 0, 1, 16'h0099, 0, 16'h0, 0, 0);
    @(posedge clk);
    #2;
    model_reset();
    push_exp();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    run(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) >= 1,
            $urandom_range(99) < 20,
            $urandom_range(99) < 70,
            $urandom_range(99) < 4,
            $urandom_range(99) < 10, 16'($urandom),
            $urandom_range(99) < 10, 16'($urandom),
            $urandom_range(99) < 5,
            $urandom_range(99) < 30);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
